// File: rtl/davos_types.sv
// Shared types for the RoCE memory responder: command layout, beat size,
// last-beat keep mask and the FSM state encodings.
package davos_types;

  localparam int MEM_BEAT_BYTES = 64;

  // length is declared first so that a cast of the 96-bit command bus puts
  // address in [63:0] and length in [95:64]
  typedef struct packed {
    logic [31:0] length;
    logic [63:0] address;
  } memCmd;

  typedef enum logic {RD_IDLE, RD_STREAM} rd_state_t;
  typedef enum logic {WR_IDLE, WR_DATA}   wr_state_t;

  // byte-valid mask for the final beat of a read; tail == 0 means a full beat
  function automatic logic [MEM_BEAT_BYTES-1:0] keep_mask(input logic [5:0] tail);
    logic [MEM_BEAT_BYTES-1:0] m;
    m = '1;
    if (tail != 6'd0) m = (64'd1 << tail) - 64'd1;
    return m;
  endfunction

endpackage

// File: rtl/roce_mem_resp_skid.sv
// Two-entry AXI-stream skid buffer on the read-data path. Falls through when
// empty; almost_full tells the read FSM to stop issuing RAM reads.
module roce_mem_resp_skid #(
  parameter int DW = 512,
  parameter int KW = 64
) (
  input  logic          net_clk,
  input  logic          net_aresetn,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic [KW-1:0] in_keep,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [KW-1:0] out_keep,
  output logic          out_last,
  output logic          almost_full
);
  localparam int W = DW + KW + 1;

  logic [1:0]   count;
  logic [W-1:0] e0, e1, in_bus;
  logic         pop;

  assign in_bus    = {in_data, in_keep, in_last};
  assign out_valid = (count != 2'd0) || in_valid;
  assign {out_data, out_keep, out_last} = (count != 2'd0) ? e0 : in_bus;
  assign pop       = out_valid && out_ready;
  // the beat currently arriving plus stored beats already fill both slots
  assign almost_full = (count == 2'd2) || (count == 2'd1 && in_valid);

  // occupancy: arrivals minus departures (an arrival popped the same cycle never lands)
  always_ff @(posedge net_clk or negedge net_aresetn)
    if (!net_aresetn) count <= 2'd0;
    else              count <= count + {1'b0, in_valid} - {1'b0, pop};

  // storage shift; writes into slots that stay unoccupied are harmless
  always_ff @(posedge net_clk)
    case (count)
      2'd0:    e0 <= in_bus;
      2'd1:    if (pop) e0 <= in_bus; else e1 <= in_bus;
      default: if (pop) begin e0 <= e1; e1 <= in_bus; end
    endcase

endmodule

// File: rtl/roce_mem_responder.sv
// Loopback host memory for the RoCE stack: services DMA read/write commands
// from an inferred dual-port byte-enable RAM. Optional command statistics
// are enabled with the ROCE_MEM_STATS_EN macro.
module roce_mem_responder
  import davos_types::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                    net_clk,
  input  logic                    net_aresetn,
  input  logic                    s_axis_mem_read_cmd_valid,
  output logic                    s_axis_mem_read_cmd_ready,
  input  logic [95:0]             s_axis_mem_read_cmd_data,
  input  logic                    s_axis_mem_write_cmd_valid,
  output logic                    s_axis_mem_write_cmd_ready,
  input  logic [95:0]             s_axis_mem_write_cmd_data,
  output logic                    m_axis_mem_read_data_valid,
  input  logic                    m_axis_mem_read_data_ready,
  output logic [DATA_WIDTH-1:0]   m_axis_mem_read_data_data,
  output logic [DATA_WIDTH/8-1:0] m_axis_mem_read_data_keep,
  output logic                    m_axis_mem_read_data_last,
  input  logic                    s_axis_mem_write_data_valid,
  output logic                    s_axis_mem_write_data_ready,
  input  logic [DATA_WIDTH-1:0]   s_axis_mem_write_data_data,
  input  logic [DATA_WIDTH/8-1:0] s_axis_mem_write_data_keep,
  input  logic                    s_axis_mem_write_data_last,
  output logic [31:0]             err_count,
  output logic [31:0]             rd_cmd_count,
  output logic [31:0]             wr_cmd_count
);
  localparam int KW = DATA_WIDTH / 8;
  localparam int AW = $clog2(MEM_DEPTH);
  localparam int BW = 27;  // ceil((2^32-1)/64) beats

  memCmd     rd_cmd, wr_cmd;
  rd_state_t rd_state, rd_state_nx;
  wr_state_t wr_state, wr_state_nx;
  logic            cmd_en;
  logic [AW-1:0]   rd_idx, wr_idx;
  logic [BW-1:0]   rd_left;
  logic [5:0]      rd_tail;
  logic            wr_drop;
  logic            rd_cmd_hs, wr_cmd_hs, wr_beat_hs, rd_out_hs, rd_issue;
  logic            rd_err, wr_err, skid_afull;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] rd_q;
  logic [KW-1:0]   rd_keep_q;
  logic            rd_v, rd_last_q;
  logic [32:0]     err_sum;
  logic [31:0]     err_q;
  logic            unused_addr_bits;

  assign rd_cmd = memCmd'(s_axis_mem_read_cmd_data);
  assign wr_cmd = memCmd'(s_axis_mem_write_cmd_data);
  assign unused_addr_bits = ^{rd_cmd.address[63:6+AW], rd_cmd.address[5:0],
                              wr_cmd.address[63:6+AW], wr_cmd.address[5:0]};

  assign s_axis_mem_read_cmd_ready   = cmd_en && (rd_state == RD_IDLE);
  assign s_axis_mem_write_cmd_ready  = cmd_en && (wr_state == WR_IDLE);
  assign s_axis_mem_write_data_ready = (wr_state == WR_DATA);

  assign rd_cmd_hs  = s_axis_mem_read_cmd_valid && s_axis_mem_read_cmd_ready;
  assign wr_cmd_hs  = s_axis_mem_write_cmd_valid && s_axis_mem_write_cmd_ready;
  assign wr_beat_hs = s_axis_mem_write_data_valid && s_axis_mem_write_data_ready;
  assign rd_out_hs  = m_axis_mem_read_data_valid && m_axis_mem_read_data_ready;
  assign rd_issue   = (rd_state == RD_STREAM) && (rd_left != '0) && !skid_afull;
  assign rd_err     = rd_cmd_hs && (rd_cmd.length == 32'd0);
  assign wr_err     = wr_cmd_hs && (wr_cmd.length == 32'd0);

  // command ports open one cycle after reset release
  always_ff @(posedge net_clk or negedge net_aresetn)
    if (!net_aresetn) cmd_en <= 1'b0;
    else              cmd_en <= 1'b1;

  // FSM state registers
  always_ff @(posedge net_clk or negedge net_aresetn)
    if (!net_aresetn) begin
      rd_state <= RD_IDLE;
      wr_state <= WR_IDLE;
    end else begin
      rd_state <= rd_state_nx;
      wr_state <= wr_state_nx;
    end

  // read FSM: zero-length commands are dropped in idle; stream ends on last output handshake
  always_comb begin
    rd_state_nx = rd_state;
    case (rd_state)
      RD_IDLE:   if (rd_cmd_hs && rd_cmd.length != 32'd0) rd_state_nx = RD_STREAM;
      RD_STREAM: if (rd_out_hs && m_axis_mem_read_data_last) rd_state_nx = RD_IDLE;
    endcase
  end

  // write FSM: the data stream's last flag ends the command whatever its length
  always_comb begin
    wr_state_nx = wr_state;
    case (wr_state)
      WR_IDLE: if (wr_cmd_hs) wr_state_nx = WR_DATA;
      WR_DATA: if (wr_beat_hs && s_axis_mem_write_data_last) wr_state_nx = WR_IDLE;
    endcase
  end

  // read address/beat bookkeeping and the RAM-read pipeline flags
  always_ff @(posedge net_clk or negedge net_aresetn)
    if (!net_aresetn) begin
      rd_idx <= '0; rd_left <= '0; rd_tail <= '0;
      rd_v <= 1'b0; rd_keep_q <= '0; rd_last_q <= 1'b0;
    end else begin
      if (rd_cmd_hs) begin
        rd_idx  <= rd_cmd.address[6 +: AW];
        rd_left <= {1'b0, rd_cmd.length[31:6]} + {{(BW-1){1'b0}}, |rd_cmd.length[5:0]};
        rd_tail <= rd_cmd.length[5:0];
      end else if (rd_issue) begin
        rd_idx  <= rd_idx + AW'(1);
        rd_left <= rd_left - BW'(1);
      end
      rd_v <= rd_issue;
      if (rd_issue) begin
        rd_last_q <= (rd_left == BW'(1));
        rd_keep_q <= (rd_left == BW'(1)) ? keep_mask(rd_tail) : '1;
      end
    end

  // write address tracking; zero-length commands consume data without writing
  always_ff @(posedge net_clk or negedge net_aresetn)
    if (!net_aresetn) begin
      wr_idx <= '0; wr_drop <= 1'b0;
    end else if (wr_cmd_hs) begin
      wr_idx  <= wr_cmd.address[6 +: AW];
      wr_drop <= (wr_cmd.length == 32'd0);
    end else if (wr_beat_hs) begin
      wr_idx  <= wr_idx + AW'(1);
    end

  // dual-port byte-enable RAM; a colliding read sees the pre-write contents
  always_ff @(posedge net_clk) begin
    if (rd_issue) rd_q <= mem[rd_idx];
    if (wr_beat_hs && !wr_drop)
      for (int b = 0; b < KW; b++)
        if (s_axis_mem_write_data_keep[b])
          mem[wr_idx][b*8 +: 8] <= s_axis_mem_write_data_data[b*8 +: 8];
  end

  roce_mem_resp_skid #(.DW(DATA_WIDTH), .KW(KW)) u_skid (
    .net_clk     (net_clk),
    .net_aresetn (net_aresetn),
    .in_valid    (rd_v),
    .in_data     (rd_q),
    .in_keep     (rd_keep_q),
    .in_last     (rd_last_q),
    .out_valid   (m_axis_mem_read_data_valid),
    .out_ready   (m_axis_mem_read_data_ready),
    .out_data    (m_axis_mem_read_data_data),
    .out_keep    (m_axis_mem_read_data_keep),
    .out_last    (m_axis_mem_read_data_last),
    .almost_full (skid_afull)
  );

  // dropped-command counter; both paths may drop in the same cycle
  assign err_sum = {1'b0, err_q} + {32'd0, rd_err} + {32'd0, wr_err};
  always_ff @(posedge net_clk or negedge net_aresetn)
    if (!net_aresetn) err_q <= '0;
    else              err_q <= err_sum[32] ? 32'hFFFF_FFFF : err_sum[31:0];
  assign err_count = err_q;

`ifdef ROCE_MEM_STATS_EN
  logic [31:0] rd_cnt_q, wr_cnt_q;
  // completed-command counters, free-running wrap
  always_ff @(posedge net_clk or negedge net_aresetn)
    if (!net_aresetn) begin
      rd_cnt_q <= '0; wr_cnt_q <= '0;
    end else begin
      if (rd_out_hs && m_axis_mem_read_data_last) rd_cnt_q <= rd_cnt_q + 32'd1;
      if (wr_beat_hs && s_axis_mem_write_data_last) wr_cnt_q <= wr_cnt_q + 32'd1;
    end
  assign rd_cmd_count = rd_cnt_q;
  assign wr_cmd_count = wr_cnt_q;
`else
  assign rd_cmd_count = '0;
  assign wr_cmd_count = '0;
`endif

endmodule

// File: tb/tb_roce_mem_responder.sv
// Directed bench for roce_mem_responder with a read-beat scoreboard and a
// reference memory model.
module tb_roce_mem_responder;
  localparam int DW = 512;
  localparam int KW = 64;
  localparam int D  = 64;
  localparam int AW = 6;

  typedef struct packed { logic [DW-1:0] d; logic [KW-1:0] k; logic l; } beat_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic rcmd_valid = 1'b0, wcmd_valid = 1'b0, rcmd_ready, wcmd_ready;
  logic [95:0] rcmd_data = '0, wcmd_data = '0;
  logic m_valid, m_ready = 1'b1, m_last;
  logic [DW-1:0] m_data;
  logic [KW-1:0] m_keep;
  logic w_valid = 1'b0, w_ready, w_last = 1'b0;
  logic [DW-1:0] w_data = '0;
  logic [KW-1:0] w_keep = '0;
  logic [31:0] err_count, rd_cnt, wr_cnt;

  int checks = 0, errors = 0;
  beat_t sb[$];
  logic [DW-1:0] ref_mem [D];
  logic [DW-1:0] wbuf [8];
  logic [KW-1:0] wkeep [8];
  logic stall_prev = 1'b0;
  beat_t prev;
  logic [3:0] pat = 4'b1001;  // ready sequence 1,0,0,1

  always #5 clk = ~clk;

  roce_mem_responder #(.DATA_WIDTH(DW), .MEM_DEPTH(D)) dut (
    .net_clk(clk), .net_aresetn(rst_n),
    .s_axis_mem_read_cmd_valid(rcmd_valid), .s_axis_mem_read_cmd_ready(rcmd_ready),
    .s_axis_mem_read_cmd_data(rcmd_data),
    .s_axis_mem_write_cmd_valid(wcmd_valid), .s_axis_mem_write_cmd_ready(wcmd_ready),
    .s_axis_mem_write_cmd_data(wcmd_data),
    .m_axis_mem_read_data_valid(m_valid), .m_axis_mem_read_data_ready(m_ready),
    .m_axis_mem_read_data_data(m_data), .m_axis_mem_read_data_keep(m_keep),
    .m_axis_mem_read_data_last(m_last),
    .s_axis_mem_write_data_valid(w_valid), .s_axis_mem_write_data_ready(w_ready),
    .s_axis_mem_write_data_data(w_data), .s_axis_mem_write_data_keep(w_keep),
    .s_axis_mem_write_data_last(w_last),
    .err_count(err_count), .rd_cmd_count(rd_cnt), .wr_cmd_count(wr_cnt)
  );

  task automatic chk(input string tag, input logic [639:0] obs, input logic [639:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [KW-1:0] kmask(input int tail);
    logic [KW-1:0] m;
    m = '0;
    if (tail == 0) m = '1;
    else for (int i = 0; i < tail; i++) m[i] = 1'b1;
    return m;
  endfunction

  // read-data monitor: scoreboard compare plus stability while stalled
  always @(negedge clk) begin
    if (!rst_n) stall_prev <= 1'b0;
    else begin
      if (stall_prev)
        chk("rd_stall_stable", {m_valid, m_data, m_keep, m_last}, {1'b1, prev});
      if (m_valid && m_ready) begin
        if (sb.size() == 0) chk("rd_unexpected_beat", m_valid, 1'b0);
        else                chk("rd_beat", {m_data, m_keep, m_last}, sb.pop_front());
      end
      stall_prev <= m_valid && !m_ready;
      prev       <= {m_data, m_keep, m_last};
    end
  end

  task automatic send_cmd(input bit rd, input logic [63:0] addr, input int len);
    int n;
    n = 0;
    @(posedge clk); #1;
    if (rd) begin rcmd_valid = 1'b1; rcmd_data = {len[31:0], addr}; end
    else    begin wcmd_valid = 1'b1; wcmd_data = {len[31:0], addr}; end
    do begin @(negedge clk); n++; end while (!(rd ? rcmd_ready : wcmd_ready) && n < 50);
    chk(rd ? "rd_cmd_accept" : "wr_cmd_accept", n < 50, 1'b1);
    @(posedge clk); #1;
    rcmd_valid = 1'b0; wcmd_valid = 1'b0;
  endtask

  task automatic wr_txn(input logic [63:0] addr, input int len, input int nb);
    int idx, n;
    idx = int'(addr[6 +: AW]);
    send_cmd(1'b0, addr, len);
    for (int k = 0; k < nb; k++) begin
      w_valid = 1'b1; w_data = wbuf[k]; w_keep = wkeep[k]; w_last = (k == nb - 1);
      n = 0;
      do begin @(negedge clk); n++; end while (!w_ready && n < 50);
      chk("wr_beat_accept", n < 50, 1'b1);
      if (len != 0)
        for (int b = 0; b < KW; b++)
          if (wkeep[k][b]) ref_mem[(idx + k) % D][b*8 +: 8] = wbuf[k][b*8 +: 8];
      @(posedge clk); #1;
    end
    w_valid = 1'b0; w_last = 1'b0;
  endtask

  task automatic push_exp(input logic [63:0] addr, input int len);
    int idx, nb;
    beat_t e;
    idx = int'(addr[6 +: AW]);
    nb  = (len + 63) / 64;
    for (int k = 0; k < nb; k++) begin
      e.d = ref_mem[(idx + k) % D];
      e.k = (k == nb - 1) ? kmask(len % 64) : {KW{1'b1}};
      e.l = (k == nb - 1);
      sb.push_back(e);
    end
  endtask

  task automatic rd_txn(input logic [63:0] addr, input int len, input bit tog);
    int n;
    push_exp(addr, len);
    send_cmd(1'b1, addr, len);
    if (len != 0) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!m_valid && n < 20);
      chk("rd_first_valid_latency", n, 2);
      n = 0;
      while (sb.size() != 0 && n < 200) begin
        @(posedge clk); #1;
        if (tog) m_ready = pat[n % 4];
        n++;
      end
      m_ready = 1'b1;
      chk("rd_drain", sb.size(), 0);
    end else repeat (8) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 8; i++) wkeep[i] = '1;
    // reset state
    #12;
    chk("rst_rcmd_ready", rcmd_ready, 1'b0);
    chk("rst_wcmd_ready", wcmd_ready, 1'b0);
    chk("rst_wdata_ready", w_ready, 1'b0);
    chk("rst_rd_valid", m_valid, 1'b0);
    chk("rst_err_count", err_count, 0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("rcmd_ready_at_release", rcmd_ready, 1'b0);
    @(posedge clk); #1;
    chk("rcmd_ready_after_release", rcmd_ready, 1'b1);
    chk("wcmd_ready_after_release", wcmd_ready, 1'b1);

    // two-beat write then readback
    wbuf[0] = {64{8'hA5}}; wbuf[1] = {64{8'h5A}};
    wr_txn(64'h0, 128, 2);
    rd_txn(64'h0, 128, 1'b0);

    // partial last beat: len 100 -> 36 valid bytes
    wbuf[0] = {16{32'hC0DE_0002}};
    wr_txn(64'h80, 64, 1);
    rd_txn(64'h40, 100, 1'b0);

    // four beats, one partially overwritten, read back under backpressure
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 16; j++) wbuf[k][j*32 +: 32] = $urandom;
    wr_txn(64'h100, 256, 4);
    wbuf[0] = {64{8'h3C}}; wkeep[0] = 64'h00FF_0000_F0F0_0001;
    wr_txn(64'h140, 64, 1);
    wkeep[0] = '1;
    rd_txn(64'h100, 256, 1'b1);

    // write and read across the top of memory
    wbuf[0] = {64{8'h11}}; wbuf[1] = {64{8'h22}};
    wr_txn(64'((D - 1) * 64), 128, 2);
    rd_txn(64'h0, 64, 1'b0);
    rd_txn(64'((D - 1) * 64), 128, 1'b0);

    // zero-length commands are counted and leave memory untouched
    rd_txn(64'h200, 0, 1'b0);
    wbuf[0] = {64{8'hEE}};
    wr_txn(64'h0, 0, 1);
    chk("err_count_len0", err_count, 2);
    rd_txn(64'h0, 64, 1'b0);
`ifdef ROCE_MEM_STATS_EN
    chk("rd_cmd_count_pre_reset", rd_cnt, 6);
`else
    chk("rd_cmd_count_pre_reset", rd_cnt, 0);
`endif

    // reset in the middle of a four-beat read
    push_exp(64'h100, 256);
    send_cmd(1'b1, 64'h100, 256);
    n = 0;
    do begin @(posedge clk); #2; n++; end while (sb.size() > 2 && n < 50);
    chk("mid_read_progress", sb.size(), 2);
    rst_n = 1'b0; #1;
    chk("rst_mid_read_valid", m_valid, 1'b0);
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("err_count_after_reset", err_count, 0);
    chk("rd_cmd_count_after_reset", rd_cnt, 0);
    chk("wr_cmd_count_after_reset", wr_cnt, 0);
    wbuf[0] = {64{8'h77}}; wbuf[1] = {64{8'h88}};
    wr_txn(64'h100, 128, 2);
    rd_txn(64'h100, 128, 1'b0);
`ifdef ROCE_MEM_STATS_EN
    chk("rd_cmd_count_final", rd_cnt, 1);
    chk("wr_cmd_count_final", wr_cnt, 1);
`else
    chk("rd_cmd_count_final", rd_cnt, 0);
    chk("wr_cmd_count_final", wr_cnt, 0);
`endif

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/roce_mem_responder.md
# roce_mem_responder

Memory-side responder for the RoCE stack's DMA command/data interfaces. Accepts read and write commands issued by the RoCE core and services them from an on-chip dual-port RAM. Read data is streamed back to the core; write data is committed with per-byte enables. Used as loopback host memory in simulation and FPGA bring-up, sitting directly opposite the stack's memory ports.

## Interface
Parameters:
- DATA_WIDTH, 512, data beat width in bits; must be 512 (64-byte beats).
- MEM_DEPTH, 1024, RAM depth in beats; power of two (64 KiB default).

Ports:
- net_clk  in  1  clock.
- net_aresetn  in  1  asynchronous, active-low reset.
- s_axis_mem_read_cmd  axis_meta.slave  96  read command: data[63:0] = byte address, data[95:64] = byte length.
- s_axis_mem_write_cmd  axis_meta.slave  96  write command, same format.
- m_axis_mem_read_data  axi_stream.master  DATA_WIDTH  read data: keep, last.
- s_axis_mem_write_data  axi_stream.slave  DATA_WIDTH  write data: keep, last; dest ignored.
- err_count  out  32  count of dropped commands.
- rd_cmd_count, wr_cmd_count  out  32 each  completed-command counters (see Configuration).

## Operation
- Addresses must be 64-byte aligned. addr[5:0] is ignored. Beat index = addr[6+:log2(MEM_DEPTH)]; it wraps modulo MEM_DEPTH.
- Read FSM, states RD_IDLE -> RD_STREAM -> RD_IDLE:
  - RD_IDLE: cmd.ready = 1. On a handshake, latch beat index and beats = ceil(len/64).
  - len == 0: drop the command, increment err_count, stay in RD_IDLE.
  - RD_STREAM: issue one RAM read per cycle while the skid buffer has space. Decrement remaining beats.
  - Last beat: keep = (len[5:0] == 0) ? all ones : ones in bits [len[5:0]-1:0], with last = 1. Other beats have keep all ones, last = 0.
  - Return to RD_IDLE once the last beat is handshaken on the output.
- Write FSM, states WR_IDLE -> WR_DATA -> WR_IDLE:
  - WR_IDLE: cmd.ready = 1, latch beat index. len == 0 increments err_count, but data is still consumed through last.
  - WR_DATA: data.ready = 1. Each beat writes RAM with byte enables = keep. Index increments with wrap.
  - The stream's last bit terminates the command, regardless of len. Then return to WR_IDLE.
  - With len == 0, beats are consumed but not written.
- Read and write paths are fully independent and may run in the same cycle.
- A same-address collision returns old data (read-first).
- err_count saturates at 0xFFFFFFFF.

## Timing
- Reset values: all valid = 0, all ready = 0 during reset. FSMs are in IDLE; counters are 0.
  - Command ready rises one cycle after deassertion.
- Read latency: cmd handshake at cycle T gives first data valid at T+2 (1 registered decode + 1 RAM).
- Full throughput of 1 beat/cycle when ready is held high.
- Backpressure: a 2-entry skid buffer absorbs in-flight RAM reads. valid/data/keep/last stay stable while ready = 0.
  - No beat is lost or duplicated.
- Write: one beat committed per data handshake. Command-to-first-accepted-beat is at least 1 cycle.
- A new command of either type is accepted no earlier than the cycle after the previous one's final beat handshake.
- Reset mid-operation aborts both FSMs immediately and flushes the skid buffer. RAM contents are undefined after reset.

## Configuration
- ROCE_MEM_STATS_EN defined: rd_cmd_count increments on the last read beat handshake. wr_cmd_count increments on the last write beat handshake. Both wrap at 2^32.
- Not defined: both outputs are tied to 0 and the counter logic is absent. err_count is always present.

## Structure
- davos_types package holds:
  - memCmd struct {address[63:0], length[31:0]}.
  - MEM_BEAT_BYTES = 64.
  - The keep-mask function.
- One sub-module, roce_mem_resp_skid: 2-entry AXI-stream skid buffer with data/keep/last and an almost-full indication to the read FSM.
- RAM is inferred inline as a true dual-port, byte-write-enable array.

## Test plan
- Write cmd addr 0x0, len 128, two beats of pattern 0xA5/0x5A. Then read cmd addr 0x0, len 128 -> two beats match, last on the second, keep all ones, first valid 2 cycles after the cmd handshake.
- Read cmd addr 0x40, len 100 -> two beats; second keep = 0x0000000FFFFFFFFF, last = 1.
- Read len 256 with output ready toggling 1,0,0,1 -> four beats in order, no drop/dup, data stable while stalled.
- Write at beat MEM_DEPTH-1, len 128 -> second beat lands at index 0; readback confirms the wrap.
- Read len 0 and write len 0 with one data beat -> err_count = 2, no read output, RAM unchanged.
- Assert net_aresetn low mid-read (beat 2 of 4) -> valid = 0 at once; after release the next read is served correctly; rd_cmd_count = 0 (with ROCE_MEM_STATS_EN).
